dff_debounce: RTL and testbench

Conditions the raw single-bit level that feeds the team's `dff` capture stage. It synchronises the asynchronous input and suppresses glitches shorter than a programmable number of clock cycles, so the flip-flop downstream samples a clean, stable level. It also emits one-cycle rise and fall pulses and keeps a wrapping count of accepted transitions for bench observation.

---
 rtl/dff_debounce.sv | 99 +++++++++
 tb/tb_dff_debounce.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_debounce.sv
// Two-flop synchroniser plus stability qualifier for a raw level feeding a dff.
// Emits registered rise/fall pulses and a wrapping count of accepted transitions.
module dff_debounce #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_in,
  output logic             q,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] edge_count
);

  localparam int unsigned CW = ($clog2(STABLE_CYCLES) > 0) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t           state, state_nx;
  logic             s1, s2;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             q_nx, rise_nx, fall_nx, busy_nx;
  logic [CNT_W-1:0] edge_count_nx;

  // Synchroniser; only s2 is used downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      q          <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      busy       <= 1'b0;
      edge_count <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      q          <= q_nx;
      rise       <= rise_nx;
      fall       <= fall_nx;
      busy       <= busy_nx;
      edge_count <= edge_count_nx;
    end
  end

  // A candidate must differ from q on STABLE_CYCLES consecutive edges; any match restarts it.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    q_nx          = q;
    rise_nx       = 1'b0;
    fall_nx       = 1'b0;
    edge_count_nx = edge_count;
    unique case (state)
      IDLE: begin
        if (s2 != q) begin
          cnt_nx   = CW'(1);
          state_nx = PENDING;
        end else begin
          cnt_nx = '0;
        end
      end
      PENDING: begin
        if (s2 == q) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (cnt == LAST) begin
          q_nx          = s2;
          rise_nx       = s2;
          fall_nx       = ~s2;
          edge_count_nx = edge_count + CNT_W'(1);
          cnt_nx        = '0;
          state_nx      = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx == PENDING);
  end

endmodule

// File: tb/tb_dff_debounce.sv
// Scoreboard bench for dff_debounce: a window-based level model predicts every
// cycle's outputs; a negedge monitor pops and compares them against the DUT.
module tb_dff_debounce;

  localparam int N = 4;

  logic       clk;
  logic       reset;
  logic       d_in;
  logic       q, rise, fall, busy;
  logic [7:0] edge_count;

  int checks   = 0;
  int failures = 0;
  int rises    = 0;
  int falls    = 0;

  logic [11:0] sb[$];

  // Reference model state: s2 seen at an edge is d_in from two edges earlier.
  logic       q_m, busy_m, rise_m, fall_m;
  logic [7:0] ec_m;
  bit         line[$];
  bit         win[$];

  dff_debounce #(.STABLE_CYCLES(N), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_in       (d_in),
    .q          (q),
    .rise       (rise),
    .fall       (fall),
    .busy       (busy),
    .edge_count (edge_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q_m = 1'b0; busy_m = 1'b0; rise_m = 1'b0; fall_m = 1'b0; ec_m = 8'd0;
    line.delete();
    line.push_back(1'b0);
    line.push_back(1'b0);
    win.delete();
  endtask

  // Accept when the last N synchronised samples all differ from the current level.
  task automatic model_edge();
    bit sv, acc;
    sv = line.pop_front();
    line.push_back(d_in);
    win.push_back(sv);
    if (win.size() > N) void'(win.pop_front());
    acc = (win.size() == N);
    foreach (win[i]) if (win[i] == q_m) acc = 1'b0;
    busy_m = (sv != q_m) && !acc;
    rise_m = acc && sv;
    fall_m = acc && !sv;
    if (acc) begin
      q_m  = sv;
      ec_m = ec_m + 8'd1;
    end
  endtask

  // One clock: advance the model at the edge, then apply new inputs and queue the expectation.
  task automatic drive(input logic d, input logic r);
    @(posedge clk);
    if (reset) model_edge();
    #3;
    d_in  = d;
    reset = r;
    if (!reset) model_reset();
    sb.push_back({q_m, busy_m, rise_m, fall_m, ec_m});
  endtask

  // Count edges until q reaches lvl, bounded.
  task automatic wait_q(input logic lvl, input int exp_n, input string nm);
    int n;
    n = 0;
    while (q !== lvl && n < 40) begin
      drive(lvl, 1'b1);
      n++;
    end
    chk(nm, n, exp_n);
  endtask

  always @(negedge clk) begin
    logic [11:0] exp;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      checks++;
      if ({q, busy, rise, fall, edge_count} !== exp) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t actual q=%b busy=%b rise=%b fall=%b cnt=%0d expected q=%b busy=%b rise=%b fall=%b cnt=%0d",
                 $time, q, busy, rise, fall, edge_count,
                 exp[11], exp[10], exp[9], exp[8], exp[7:0]);
      end
      if (rise === 1'b1) rises++;
      if (fall === 1'b1) falls++;
    end
  end

  initial begin
    int r0, f0;
    reset = 1'b0;
    d_in  = 1'b1;
    model_reset();

    // Reset held with d_in high, then released
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    chk("reset_q", int'(q), 0);
    chk("reset_count", int'(edge_count), 0);
    r0 = rises;
    drive(1'b1, 1'b1);
    wait_q(1'b1, 6, "reset_release_latency");
    drive(1'b1, 1'b1);
    chk("reset_release_rises", rises - r0, 1);
    chk("reset_release_count", int'(edge_count), 1);

    // Fall then clean rise
    drive(1'b0, 1'b1);
    wait_q(1'b0, 6, "fall_latency");
    repeat (3) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    wait_q(1'b1, 6, "clean_rise_latency");
    drive(1'b1, 1'b1);
    chk("clean_rise_count", int'(edge_count), 3);

    // Glitch of 3 cycles from a low level
    drive(1'b0, 1'b1);
    wait_q(1'b0, 6, "fall2_latency");
    repeat (3) drive(1'b0, 1'b1);
    r0 = rises; f0 = falls;
    repeat (3) drive(1'b1, 1'b1);
    repeat (10) drive(1'b0, 1'b1);
    chk("glitch_rises", rises - r0, 0);
    chk("glitch_falls", falls - f0, 0);
    chk("glitch_q", int'(q), 0);

    // Reversal: high 3, low 1, then high held
    repeat (3) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    wait_q(1'b1, 6, "reversal_latency");

    // Reset in the middle of qualifying a rise
    drive(1'b0, 1'b1);
    wait_q(1'b0, 6, "fall3_latency");
    repeat (3) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    repeat (3) drive(1'b1, 1'b1);
    chk("pending_busy", int'(busy), 1);
    drive(1'b1, 1'b0);
    #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_q", int'(q), 0);
    drive(1'b1, 1'b0);
    r0 = rises;
    drive(1'b1, 1'b1);
    wait_q(1'b1, 6, "midreset_latency");
    drive(1'b1, 1'b1);
    chk("midreset_rises", rises - r0, 1);
    chk("midreset_count", int'(edge_count), 1);

    // 256 alternating accepted transitions from a fresh reset
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b1);
    r0 = rises; f0 = falls;
    for (int i = 0; i < 256; i++) begin
      repeat (8) drive(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1);
    end
    repeat (4) drive(1'b0, 1'b1);
    chk("wrap_count", int'(edge_count), 0);
    chk("wrap_rises", rises - r0, 128);
    chk("wrap_falls", falls - f0, 128);
    chk("wrap_q", int'(q), 0);

    // Random level segments with occasional resets
    for (int s = 0; s < 80; s++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      if ($urandom_range(0, 19) == 0) begin
        repeat (int'($urandom_range(1, 2))) drive(lvl, 1'b0);
      end
      repeat (len) drive(lvl, 1'b1);
    end
    repeat (10) drive(d_in, 1'b1);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
